// File: rtl/cmem_arbiter.sv
// cmem_arbiter: serialises cpu ifetch (a) and data (b) cache ports onto one pmem port.
// Optional CMEM_ARB_ROUND_ROBIN_EN swaps fixed b>a priority for alternating grants.
module cmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmem_read_a,
    input  logic                    cmem_write_a,
    input  logic [DATA_WIDTH/8-1:0] cmem_byte_enable_a,
    input  logic [ADDR_WIDTH-1:0]   cmem_address_a,
    input  logic [DATA_WIDTH-1:0]   cmem_wdata_a,
    output logic                    cmem_resp_a,
    output logic [DATA_WIDTH-1:0]   cmem_rdata_a,
    input  logic                    cmem_read_b,
    input  logic                    cmem_write_b,
    input  logic [DATA_WIDTH/8-1:0] cmem_byte_enable_b,
    input  logic [ADDR_WIDTH-1:0]   cmem_address_b,
    input  logic [DATA_WIDTH-1:0]   cmem_wdata_b,
    output logic                    cmem_resp_b,
    output logic [DATA_WIDTH-1:0]   cmem_rdata_b,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [DATA_WIDTH/8-1:0] pmem_byte_enable,
    output logic [ADDR_WIDTH-1:0]   pmem_address,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
    input  logic                    pmem_resp,
    input  logic [DATA_WIDTH-1:0]   pmem_rdata
);

    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_A,
        BUSY_B,
        RESP_A,
        RESP_B
    } state_e;

    state_e                state_q, state_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [BW-1:0]         be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;

    logic req_a, req_b, grant_b;

    assign req_a = cmem_read_a | cmem_write_a;
    assign req_b = cmem_read_b | cmem_write_b;

`ifdef CMEM_ARB_ROUND_ROBIN_EN
    // last_q: 1 = b was granted most recently
    logic last_q, last_d;
    assign grant_b = req_b & (~req_a | ~last_q);
`else
    assign grant_b = req_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
`ifdef CMEM_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
`ifdef CMEM_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
`ifdef CMEM_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_b) begin
                    rd_d    = cmem_read_b & ~cmem_write_b;
                    wr_d    = cmem_write_b;
                    be_d    = cmem_byte_enable_b;
                    addr_d  = cmem_address_b;
                    wdata_d = cmem_wdata_b;
                    state_d = BUSY_B;
`ifdef CMEM_ARB_ROUND_ROBIN_EN
                    last_d  = 1'b1;
`endif
                end else if (req_a) begin
                    rd_d    = cmem_read_a & ~cmem_write_a;
                    wr_d    = cmem_write_a;
                    be_d    = cmem_byte_enable_a;
                    addr_d  = cmem_address_a;
                    wdata_d = cmem_wdata_a;
                    state_d = BUSY_A;
`ifdef CMEM_ARB_ROUND_ROBIN_EN
                    last_d  = 1'b0;
`endif
                end
            end
            BUSY_A: begin
                if (pmem_resp) begin
                    rdata_a_d = wr_q ? '0 : pmem_rdata;
                    state_d   = RESP_A;
                end
            end
            BUSY_B: begin
                if (pmem_resp) begin
                    rdata_b_d = wr_q ? '0 : pmem_rdata;
                    state_d   = RESP_B;
                end
            end
            RESP_A:  state_d = IDLE;
            RESP_B:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic busy;
    assign busy = (state_q == BUSY_A) | (state_q == BUSY_B);

    assign pmem_read        = busy & rd_q;
    assign pmem_write       = busy & wr_q;
    assign pmem_byte_enable = be_q;
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;

    assign cmem_resp_a  = (state_q == RESP_A);
    assign cmem_resp_b  = (state_q == RESP_B);
    assign cmem_rdata_a = rdata_a_q;
    assign cmem_rdata_b = rdata_b_q;

endmodule
